// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, forwarding selects and stage record for alu_hazard_ctrl
package alu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int ZF = 2;
    localparam int NF = 1;
    localparam int OF = 0;

    typedef struct packed {
        logic       valid;
        logic       wen;
        logic [4:0] dest;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rs;
        logic       uses_rt;
        logic       is_load;
        logic       br_eq;
        logic       br_ne;
        logic       ovf_chk;
    } stage_rec_t;

    // Loads in MEM are excluded: the load-use stall keeps that case from arising.
    function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] src,
                                           input stage_rec_t mem, input stage_rec_t wb);
        if (!used)
            return FWD_RF;
        if (mem.valid && mem.wen && !mem.is_load && mem.dest == src)
            return FWD_MEM;
        if (wb.valid && wb.wen && wb.dest == src)
            return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/alu_instr_decode.sv
// rtl/alu_instr_decode.sv - combinational decode of one instruction word into a stage record
module alu_instr_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    output stage_rec_t  rec_o
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       instr_unused;

    assign op           = instr_i[31:26];
    assign funct        = instr_i[5:0];
    assign instr_unused = ^instr_i[10:6];

    always_comb begin
        rec_o       = '0;
        rec_o.valid = 1'b1;
        rec_o.rs    = instr_i[25:21];
        rec_o.rt    = instr_i[20:16];
        case (op)
            OP_RTYPE: begin
                rec_o.dest    = instr_i[15:11];
                rec_o.uses_rt = 1'b1;
                rec_o.uses_rs = !(funct inside {FN_SLL, FN_SRL, FN_SRA});
                rec_o.ovf_chk = (funct == FN_ADD) || (funct == FN_SUB);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                rec_o.dest    = instr_i[20:16];
                rec_o.uses_rs = 1'b1;
                rec_o.ovf_chk = (op == OP_ADDI);
            end
            OP_LW: begin
                rec_o.dest    = instr_i[20:16];
                rec_o.uses_rs = 1'b1;
                rec_o.is_load = 1'b1;
            end
            OP_SW: begin
                rec_o.uses_rs = 1'b1;
                rec_o.uses_rt = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                rec_o.uses_rs = 1'b1;
                rec_o.uses_rt = 1'b1;
                rec_o.br_eq   = (op == OP_BEQ);
                rec_o.br_ne   = (op == OP_BNE);
            end
            default: ;
        endcase
        // $0 is hardwired, so writing it is never a real write.
        rec_o.wen = (rec_o.dest != 5'd0);
    end

endmodule

// File: rtl/alu_hazard_ctrl.sv
// rtl/alu_hazard_ctrl.sv - stall, forward, flush and overflow-cancel control for the shared ALU
module alu_hazard_ctrl
    import alu_pkg::*;
#(
    parameter int OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [31:0]          id_instr,
    input  logic [2:0]           ex_alu_flags,
    output logic                 stall,
    output logic                 flush,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic                 ex_valid,
    output logic                 mem_wen,
    output logic                 wb_wen,
    output logic [4:0]           wb_dest,
    output logic                 ovf_pulse,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    stage_rec_t           id_rec;
    stage_rec_t           ex_q, ex_d;
    stage_rec_t           mem_q, mem_d;
    stage_rec_t           wb_q;
    logic [OVF_CNT_W-1:0] ovf_count_q, ovf_count_d;
    logic                 taken;
    logic                 hazard;
    logic                 ovf_hit;
    logic                 neg_unused;

    assign neg_unused = ex_alu_flags[NF];

    alu_instr_decode u_decode (
        .instr_i (id_instr),
        .rec_o   (id_rec)
    );

    always_comb begin
        taken  = ex_q.valid && ((ex_q.br_eq && ex_alu_flags[ZF]) ||
                                (ex_q.br_ne && !ex_alu_flags[ZF]));
        hazard = id_valid && ex_q.valid && ex_q.is_load && ex_q.wen &&
                 ((id_rec.uses_rs && id_rec.rs == ex_q.dest) ||
                  (id_rec.uses_rt && id_rec.rt == ex_q.dest));
        ovf_hit = ex_q.valid && ex_q.ovf_chk && ex_alu_flags[OF];

        // A taken branch squashes ID, so it also overrides any pending stall.
        ex_d = '0;
        if (id_valid && !taken && !hazard)
            ex_d = id_rec;

        mem_d = ex_q;
        if (ovf_hit)
            mem_d.wen = 1'b0;

        ovf_count_d = ovf_count_q;
        if (ovf_hit && !(&ovf_count_q))
            ovf_count_d = ovf_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            ovf_count_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= mem_q;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign stall     = hazard && !taken;
    assign flush     = taken;
    assign fwd_a     = ex_q.valid ? fwd_sel(ex_q.uses_rs, ex_q.rs, mem_q, wb_q) : FWD_RF;
    assign fwd_b     = ex_q.valid ? fwd_sel(ex_q.uses_rt, ex_q.rt, mem_q, wb_q) : FWD_RF;
    assign ex_valid  = ex_q.valid;
    assign mem_wen   = mem_q.valid && mem_q.wen;
    assign wb_wen    = wb_q.valid && wb_q.wen;
    assign wb_dest   = wb_q.dest;
    assign ovf_pulse = ovf_hit;
    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_alu_hazard_ctrl.sv
// tb/tb_alu_hazard_ctrl.sv - directed bench with an instruction-level pipeline model for alu_hazard_ctrl
module tb_alu_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [2:0]  ex_alu_flags;
    logic        stall, flush, ex_valid, mem_wen, wb_wen, ovf_pulse;
    logic [1:0]  fwd_a, fwd_b;
    logic [4:0]  wb_dest;
    logic [7:0]  ovf_count;

    alu_hazard_ctrl #(.OVF_CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .ex_alu_flags (ex_alu_flags),
        .stall        (stall),
        .flush        (flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .ex_valid     (ex_valid),
        .mem_wen      (mem_wen),
        .wb_wen       (wb_wen),
        .wb_dest      (wb_dest),
        .ovf_pulse    (ovf_pulse),
        .ovf_count    (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit v;
        bit wr;
        int dest;
        int s0;
        int s1;
        bit ld;
        bit beq;
        bit bne;
        bit ovc;
    } minstr_t;

    minstr_t m_ex, m_mem, m_wb;
    int      m_cnt;
    int      checks = 0;
    int      errors = 0;
    bit      chk_en = 0;
    int      exp_stall, exp_flush, exp_fa, exp_fb, exp_exv, exp_memw, exp_wbw, exp_wbd, exp_ovf, exp_cnt;

    function automatic minstr_t bubble();
        minstr_t m;
        m.v = 0; m.wr = 0; m.dest = 0; m.s0 = -1; m.s1 = -1;
        m.ld = 0; m.beq = 0; m.bne = 0; m.ovc = 0;
        return m;
    endfunction

    function automatic minstr_t mdec(input logic [31:0] w);
        minstr_t m;
        int op, fn, rs, rt, rd;
        op = int'(w[31:26]); fn = int'(w[5:0]);
        rs = int'(w[25:21]); rt = int'(w[20:16]); rd = int'(w[15:11]);
        m = bubble();
        m.v = 1;
        if (op == 0) begin
            m.dest = rd; m.s1 = rt;
            if (!(fn == 0 || fn == 2 || fn == 3)) m.s0 = rs;
            m.ovc = (fn == 32 || fn == 34);
        end else if (op >= 8 && op <= 14) begin
            m.dest = rt; m.s0 = rs; m.ovc = (op == 8);
        end else if (op == 35) begin
            m.dest = rt; m.s0 = rs; m.ld = 1;
        end else if (op == 43) begin
            m.s0 = rs; m.s1 = rt;
        end else if (op == 4 || op == 5) begin
            m.s0 = rs; m.s1 = rt; m.beq = (op == 4); m.bne = (op == 5);
        end
        m.wr = (m.dest != 0);
        return m;
    endfunction

    function automatic int fsel(input int s);
        if (s < 0) return 0;
        if (m_mem.v && m_mem.wr && !m_mem.ld && m_mem.dest == s) return 1;
        if (m_wb.v && m_wb.wr && m_wb.dest == s) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(stall), exp_stall);
            chk("flush", 32'(flush), exp_flush);
            chk("fwd_a", 32'(fwd_a), exp_fa);
            chk("fwd_b", 32'(fwd_b), exp_fb);
            chk("ex_valid", 32'(ex_valid), exp_exv);
            chk("mem_wen", 32'(mem_wen), exp_memw);
            chk("wb_wen", 32'(wb_wen), exp_wbw);
            if (exp_wbw != 0) chk("wb_dest", 32'(wb_dest), exp_wbd);
            chk("ovf_pulse", 32'(ovf_pulse), exp_ovf);
            chk("ovf_count", 32'(ovf_count), exp_cnt);
        end
    end

    task automatic cyc(input bit v, input logic [31:0] ins, input logic [2:0] f);
        minstr_t idm;
        bit      z;
        id_valid = v; id_instr = ins; ex_alu_flags = f;
        idm = mdec(ins);
        z = f[2];
        exp_flush = int'(m_ex.v && ((m_ex.beq && z) || (m_ex.bne && !z)));
        exp_stall = int'(v && m_ex.v && m_ex.ld && m_ex.wr &&
                         (idm.s0 == m_ex.dest || idm.s1 == m_ex.dest) && exp_flush == 0);
        exp_fa   = m_ex.v ? fsel(m_ex.s0) : 0;
        exp_fb   = m_ex.v ? fsel(m_ex.s1) : 0;
        exp_exv  = int'(m_ex.v);
        exp_memw = int'(m_mem.v && m_mem.wr);
        exp_wbw  = int'(m_wb.v && m_wb.wr);
        exp_wbd  = m_wb.dest;
        exp_ovf  = int'(m_ex.v && m_ex.ovc && f[0]);
        exp_cnt  = m_cnt;
        @(negedge clk);
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        if (!rst_n) begin
            m_ex = bubble(); m_mem = bubble(); m_wb = bubble(); m_cnt = 0;
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            if (exp_ovf != 0) m_mem.wr = 0;
            if (!id_valid || exp_flush != 0 || exp_stall != 0) m_ex = bubble();
            else m_ex = mdec(id_instr);
            if (exp_ovf != 0 && m_cnt < 255) m_cnt++;
        end
        #1;
    endtask

    task automatic step(input bit v, input logic [31:0] ins, input logic [2:0] f);
        cyc(v, ins, f);
        adv();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(0, 32'd0, 3'd0);
    endtask

    initial begin
        logic [31:0] lw2, add3, add5, sub6, beq12, bne12, add7, addu7, add8;
        lw2   = itype(35, 1, 2, 0);
        add3  = rtype(2, 4, 3, 32);
        add5  = rtype(1, 1, 5, 32);
        sub6  = rtype(5, 5, 6, 34);
        beq12 = itype(4, 1, 2, 8);
        bne12 = itype(5, 1, 2, 8);
        add7  = rtype(1, 2, 7, 32);
        addu7 = rtype(1, 2, 7, 33);
        add8  = rtype(1, 1, 8, 32);
        m_ex = bubble(); m_mem = bubble(); m_wb = bubble(); m_cnt = 0;

        rst_n = 0;
        step(0, 32'd0, 3'd0);
        step(0, 32'd0, 3'd0);
        chk_en = 1;
        rst_n = 1;
        cyc(0, 32'd0, 3'd0);
        chk("reset_ex_valid", 32'(ex_valid), 0);
        chk("reset_ovf_count", 32'(ovf_count), 0);
        adv();

        // load-use: one stall cycle, bubble in EX, then WB forwarding
        step(1, lw2, 3'd0);
        cyc(1, add3, 3'd0);
        chk("lu_stall", 32'(stall), 1);
        adv();
        cyc(1, add3, 3'd0);
        chk("lu_stall_once", 32'(stall), 0);
        chk("lu_bubble", 32'(ex_valid), 0);
        adv();
        cyc(0, 32'd0, 3'd0);
        chk("lu_fwd_a", 32'(fwd_a), 2);
        adv();
        drain(3);

        // back-to-back ALU dependency, then with a NOP gap
        step(1, add5, 3'd0);
        step(1, sub6, 3'd0);
        cyc(0, 32'd0, 3'd0);
        chk("b2b_fwd_a", 32'(fwd_a), 1);
        chk("b2b_fwd_b", 32'(fwd_b), 1);
        adv();
        drain(3);
        step(1, add5, 3'd0);
        step(0, 32'd0, 3'd0);
        step(1, sub6, 3'd0);
        cyc(0, 32'd0, 3'd0);
        chk("gap_fwd_a", 32'(fwd_a), 2);
        chk("gap_fwd_b", 32'(fwd_b), 2);
        adv();
        drain(3);

        // branches with zero flag set
        step(1, beq12, 3'd0);
        cyc(1, add8, 3'b100);
        chk("beq_flush", 32'(flush), 1);
        adv();
        cyc(0, 32'd0, 3'd0);
        chk("beq_bubble", 32'(ex_valid), 0);
        adv();
        drain(2);
        step(1, bne12, 3'd0);
        cyc(1, add8, 3'b100);
        chk("bne_noflush", 32'(flush), 0);
        adv();
        cyc(0, 32'd0, 3'd0);
        chk("bne_next_valid", 32'(ex_valid), 1);
        adv();
        drain(3);

        // overflow cancels a write; addu is never checked
        step(1, add7, 3'd0);
        cyc(0, 32'd0, 3'b001);
        chk("ovf_pulse", 32'(ovf_pulse), 1);
        adv();
        cyc(0, 32'd0, 3'd0);
        chk("ovf_mem_wen", 32'(mem_wen), 0);
        chk("ovf_count1", 32'(ovf_count), 1);
        adv();
        cyc(0, 32'd0, 3'd0);
        chk("ovf_wb_wen", 32'(wb_wen), 0);
        adv();
        step(1, addu7, 3'd0);
        cyc(0, 32'd0, 3'b001);
        chk("addu_nopulse", 32'(ovf_pulse), 0);
        adv();
        cyc(0, 32'd0, 3'd0);
        chk("addu_mem_wen", 32'(mem_wen), 1);
        adv();
        cyc(0, 32'd0, 3'd0);
        chk("addu_wb_dest", 32'(wb_dest), 7);
        adv();

        // 300 overflow events saturate the counter
        for (int i = 0; i < 300; i++) step(1, add7, 3'b001);
        step(0, 32'd0, 3'b001);
        cyc(0, 32'd0, 3'd0);
        chk("ovf_saturate", 32'(ovf_count), 255);
        adv();
        drain(3);

        // taken branch with a dependent instruction in ID
        step(1, beq12, 3'd0);
        cyc(1, add3, 3'b100);
        chk("br_flush", 32'(flush), 1);
        chk("br_nostall", 32'(stall), 0);
        adv();
        drain(3);

        // reset in the middle of a stall
        step(1, lw2, 3'd0);
        rst_n = 0;
        cyc(1, add3, 3'd0);
        chk("rst_mid_stall", 32'(stall), 1);
        adv();
        rst_n = 1;
        cyc(0, 32'd0, 3'd0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_mem_wen", 32'(mem_wen), 0);
        chk("rst_wb_wen", 32'(wb_wen), 0);
        chk("rst_count", 32'(ovf_count), 0);
        adv();
        drain(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/alu_hazard_ctrl.md
Name: alu_hazard_ctrl

Overview:
- Pipeline controller that sequences the shared ALU in the 5-stage MIPS core.
- Tracks the destination, load, branch and overflow-class attributes of each instruction as it moves from ID through EX, MEM and WB.
- Generates load-use stalls, ALU operand forwarding selects, branch flushes from the ALU zero flag, and write-enable cancellation on ALU overflow.
- Sits beside the ID/EX/MEM/WB pipeline registers. It owns no data; it only produces control.

Parameters:
- OVF_CNT_W, 8, width of the saturating overflow-event counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_instr  in  32  instruction currently in ID.
- ex_alu_flags  in  3  ALU flags for the EX instruction: [2] zero, [1] negative, [0] overflow.
- stall  out  1  hold PC and IF/ID; insert bubble into EX.
- flush  out  1  squash IF and ID; redirect fetch to the branch target.
- fwd_a  out  2  ALU operand A select for EX: 00 register file, 01 MEM result, 10 WB result.
- fwd_b  out  2  ALU operand B select, same encoding as fwd_a.
- ex_valid  out  1  EX holds a live instruction.
- mem_wen  out  1  MEM instruction will write the register file.
- wb_wen  out  1  register-file write enable this cycle.
- wb_dest  out  5  register-file write address.
- ovf_pulse  out  1  one-cycle pulse when an overflow cancels a write.
- ovf_count  out  OVF_CNT_W  saturating count of cancelled writes.

Behaviour:
- Reset: on rising clk with rst_n=0, all stage records are invalid and ovf_count=0. All outputs read 0 from the following cycle. A reset mid-stall or mid-flush aborts that operation.
- ID decode, combinational:
  - R-type (op 000000) writes rd and reads rs, rt.
  - sll, srl, sra read rt only.
  - addi, addiu, andi, ori, xori, slti, sltiu write rt and read rs.
  - lw writes rt, reads rs, and sets is_load.
  - sw reads rs, rt; no write.
  - beq, bne read rs, rt and set br_eq or br_ne.
  - add, addi, sub set ovf_chk.
  - Any other opcode is a NOP.
  - A destination of $0 never counts as a write.
- Stage records: each of EX, MEM and WB holds {valid, wen, dest, rs, rt, uses_rs, uses_rt, is_load, br_eq, br_ne, ovf_chk}. Every cycle, EX moves to MEM and MEM moves to WB.
- Load-use stall: stall=1 when id_valid, EX.valid, EX.is_load, EX.wen, and EX.dest matches a register ID uses. During a stall the ID instruction is held and a bubble enters EX. The stall lasts exactly 1 cycle per hazard.
- Branch resolution in EX: taken = EX.valid and ((br_eq and zero) or (br_ne and not zero)).
  - flush=1 combinationally in that cycle.
  - The next EX record is a bubble.
  - Penalty is 2 squashed slots (IF and ID).
- Overflow: if EX.valid, EX.ovf_chk and ex_alu_flags[0]=1, the record advances to MEM with wen=0. In the same cycle ovf_pulse=1 and ovf_count increments, saturating at all-ones. The negative flag is ignored.
- Forwarding, combinational from the registered state:
  - For each of EX.rs and EX.rt (only if used): select 01 if MEM.valid, MEM.wen and MEM.dest matches.
  - Otherwise select 10 if WB.valid, WB.wen and WB.dest matches.
  - Otherwise select 00.
  - MEM takes priority over WB. A load in MEM is never forwarded; the stall guarantees this case cannot occur.
- wb_wen = WB.valid and WB.wen; wb_dest = WB.dest. mem_wen and ex_valid are driven the same way from their stage records.
- Simultaneous events:
  - Flush beats stall: the ID instruction is squashed, so stall=0.
  - An overflow-cancelled record still advances to MEM; it does not stall.

Decomposition:
- Shared package alu_pkg holds:
  - opcode and funct localparams.
  - forwarding-select constants FWD_RF, FWD_MEM, FWD_WB.
  - the stage-record struct typedef.
  - flag bit indices ZF=2, NF=1, OF=0.
- One sub-module, alu_instr_decode: purely combinational decode of id_instr into a stage record. It is reusable by the main decoder.

Test Plan:
- lw $2,0($1); add $3,$2,$4 back-to-back -> stall=1 for exactly 1 cycle, then fwd_a=10 when the add reaches EX; ex_valid=0 during the bubble.
- add $5,$1,$1; sub $6,$5,$5 -> no stall; fwd_a=01 and fwd_b=01 with sub in EX. Insert one NOP between them -> both selects 10.
- beq in EX with ex_alu_flags=3'b100 -> flush=1 for 1 cycle and next ex_valid=0. Same with bne -> flush=0.
- add $7,... in EX with ex_alu_flags=3'b001 -> ovf_pulse=1, mem_wen=0 next cycle, wb_wen=0 two cycles later, ovf_count 0->1. Same with addu -> no pulse.
- 300 overflowing adds -> ovf_count saturates at 8'hFF.
- Taken branch in EX while a load-use hazard sits in ID -> flush=1 and stall=0. rst_n=0 mid-stall -> all outputs 0 next cycle.
